// File: rtl/serv_stoc_s2b.sv
// Stochastic-to-binary converter: counts the ones in a W-bit stochastic stream
// over 2^LEN_LOG2 valid samples and hands the count off through valid/ready.
module serv_stoc_s2b #(
  parameter int unsigned W        = 1,
  parameter int unsigned LEN_LOG2 = 8,
  parameter int unsigned CNT_W    = LEN_LOG2 + $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_valid,
  input  logic [W-1:0]     i_stream,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    acc, acc_nxt, pop, cnt_nxt;
  logic [LEN_LOG2-1:0] smp, smp_nxt;
  logic                valid_nxt;
  logic                last;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pop = pop + CNT_W'(i_stream[i]);
    end
  end

  assign last = (smp == '1);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    smp_nxt   = smp;
    cnt_nxt   = o_cnt;
    valid_nxt = o_valid;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          smp_nxt   = '0;
        end
      end
      ACCUM: begin
        // Abort wins over a completing last sample in the same cycle.
        if (i_abort) begin
          state_nxt = IDLE;
        end else if (i_valid) begin
          acc_nxt = acc + pop;
          smp_nxt = smp + 1'b1;
          if (last) begin
            state_nxt = HOLD;
            cnt_nxt   = acc + pop;
            valid_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          valid_nxt = 1'b0;
          if (i_start) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            smp_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      smp     <= '0;
      o_cnt   <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      smp     <= smp_nxt;
      o_cnt   <= cnt_nxt;
      o_valid <= valid_nxt;
      o_busy  <= (state_nxt == ACCUM);
    end
  end

endmodule

// File: tb/tb_serv_stoc_s2b.sv
// Directed bench for serv_stoc_s2b: a W=1/LEN_LOG2=4 instance and a W=4/LEN_LOG2=2 instance.
module tb_serv_stoc_s2b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: W=1, LEN_LOG2=4, CNT_W=5
  logic       a_rst, a_start, a_abort, a_valid, a_ready;
  logic [0:0] a_stream;
  logic       a_busy, a_ovalid;
  logic [4:0] a_cnt;

  // Instance B: W=4, LEN_LOG2=2, CNT_W=5
  logic       b_rst, b_start, b_abort, b_valid, b_ready;
  logic [3:0] b_stream;
  logic       b_busy, b_ovalid;
  logic [4:0] b_cnt;

  serv_stoc_s2b #(.W(1), .LEN_LOG2(4)) dut_a (
    .clk(clk), .i_rst(a_rst), .i_start(a_start), .i_abort(a_abort),
    .i_valid(a_valid), .i_stream(a_stream), .o_busy(a_busy),
    .o_cnt(a_cnt), .o_valid(a_ovalid), .i_ready(a_ready)
  );

  serv_stoc_s2b #(.W(4), .LEN_LOG2(2)) dut_b (
    .clk(clk), .i_rst(b_rst), .i_start(b_start), .i_abort(b_abort),
    .i_valid(b_valid), .i_stream(b_stream), .o_busy(b_busy),
    .o_cnt(b_cnt), .o_valid(b_ovalid), .i_ready(b_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; return #1 after the edge so outputs are settled.
  task automatic a_cyc(input logic s, input logic ab, input logic v, input logic st, input logic r);
    a_start = s; a_abort = ab; a_valid = v; a_stream = st; a_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic b_cyc(input logic s, input logic ab, input logic v, input logic [3:0] st, input logic r);
    b_start = s; b_abort = ab; b_valid = v; b_stream = st; b_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    int nv;
    int cyc;
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 0; a_stream = 0; a_ready = 0;
    b_start = 0; b_abort = 0; b_valid = 0; b_stream = 0; b_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_a_valid", a_ovalid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_valid", b_ovalid, 0);
    a_rst = 1'b0; b_rst = 1'b0;

    // 1: all-ones window, ready held high
    a_cyc(1, 0, 0, 0, 1);
    check("t1_busy", a_busy, 1);
    for (int i = 0; i < 16; i++) begin
      a_cyc(0, 0, 1, 1, 1);
      if (i == 14) check("t1_valid_early", a_ovalid, 0);
    end
    check("t1_valid", a_ovalid, 1);
    check("t1_cnt", a_cnt, 16);
    check("t1_busy_hold", a_busy, 0);
    a_cyc(0, 0, 0, 0, 1);
    check("t1_valid_drop", a_ovalid, 0);
    check("t1_idle_busy", a_busy, 0);
    check("t1_cnt_kept", a_cnt, 16);

    // 2: alternating stream with a gap every third cycle
    a_cyc(1, 0, 0, 0, 1);
    nv = 0; cyc = 0;
    while (nv < 16 && cyc < 100) begin
      if (cyc % 3 == 2) begin
        a_cyc(0, 0, 0, 1, 1);
      end else begin
        a_cyc(0, 0, 1, (nv % 2 == 0) ? 1'b1 : 1'b0, 1);
        nv++;
      end
      if (nv < 16 && a_ovalid !== 1'b0) check("t2_valid_early", a_ovalid, 0);
      cyc++;
    end
    check("t2_samples", nv, 16);
    check("t2_valid", a_ovalid, 1);
    check("t2_cnt", a_cnt, 8);
    a_cyc(0, 0, 0, 0, 1);
    check("t2_valid_drop", a_ovalid, 0);

    // 3: back-pressure for 5 cycles with start and samples driven
    a_cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) a_cyc(0, 0, 1, (i < 5) ? 1'b1 : 1'b0, 0);
    check("t3_cnt", a_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      a_cyc(1, 0, 1, 1, 0);
      check("t3_hold_valid", a_ovalid, 1);
      check("t3_hold_cnt", a_cnt, 5);
      check("t3_hold_busy", a_busy, 0);
    end
    a_cyc(0, 0, 0, 0, 1);
    check("t3_handshake", a_ovalid, 0);
    check("t3_idle_busy", a_busy, 0);

    // 4: abort mid-run, then abort coinciding with the last sample
    a_cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) a_cyc(0, 0, 1, 1, 1);
    a_cyc(0, 1, 0, 0, 1);
    check("t4a_busy", a_busy, 0);
    check("t4a_valid", a_ovalid, 0);
    a_cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) a_cyc(0, 0, 1, 1, 1);
    a_cyc(0, 1, 1, 1, 1);
    check("t4b_valid", a_ovalid, 0);
    check("t4b_busy", a_busy, 0);
    a_cyc(0, 0, 0, 0, 1);
    check("t4b_valid_later", a_ovalid, 0);
    a_cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) a_cyc(0, 0, 1, (i < 3) ? 1'b1 : 1'b0, 1);
    check("t4c_valid", a_ovalid, 1);
    check("t4c_cnt", a_cnt, 3);
    a_cyc(0, 0, 0, 0, 1);

    // 5: reset mid-accumulation, then an all-zero run
    a_cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) a_cyc(0, 0, 1, 1, 1);
    a_rst = 1'b1;
    a_cyc(1, 0, 1, 1, 1);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_valid", a_ovalid, 0);
    check("t5_rst_cnt", a_cnt, 0);
    a_rst = 1'b0;
    a_cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) a_cyc(0, 0, 1, 0, 0);
    check("t5_valid", a_ovalid, 1);
    check("t5_cnt", a_cnt, 0);
    a_cyc(0, 0, 0, 0, 1);

    // 6: multi-bit stream with back-to-back restart during handshake
    b_cyc(1, 0, 0, 4'b0000, 0);
    check("t6_busy", b_busy, 1);
    b_cyc(0, 0, 1, 4'b1111, 0);
    b_cyc(0, 0, 1, 4'b0101, 0);
    b_cyc(0, 0, 1, 4'b0000, 0);
    b_cyc(0, 0, 1, 4'b1000, 0);
    check("t6_valid", b_ovalid, 1);
    check("t6_cnt", b_cnt, 7);
    b_cyc(1, 0, 0, 4'b0000, 1);
    check("t6_b2b_valid", b_ovalid, 0);
    check("t6_b2b_busy", b_busy, 1);
    for (int i = 0; i < 4; i++) b_cyc(0, 0, 1, 4'b1111, 0);
    check("t6_full_valid", b_ovalid, 1);
    check("t6_full_cnt", b_cnt, 16);
    b_cyc(0, 0, 0, 4'b0000, 1);
    check("t6_full_drop", b_ovalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
